// File: rtl/snn_lif_layer.sv
// snn_lif_layer: one fully connected leaky integrate-and-fire layer; inputs are integrated one index per clock.
// Define SNN_SPIKE_COUNT_EN to build the per-neuron saturating spike counters behind spike_cnt.
module snn_lif_layer #(
    parameter int N_IN                = 4,
    parameter int N_OUT               = 2,
    parameter int N_CYCLES            = 10,
    parameter int CYCLES_CNT_BITWIDTH = 5,
    parameter int W_WIDTH             = 8,
    parameter int V_WIDTH             = 12,
    parameter int THRESHOLD           = 64,
    parameter int LEAK_SHIFT          = 3,
    parameter int CNT_WIDTH           = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    output logic                                           ready,
    output logic                                           sample,
    input  logic                                           sample_ready,
    input  logic [N_IN-1:0]                                in_spikes,
    output logic [N_OUT-1:0]                               out_spikes,
    output logic                                           out_valid,
    output logic                                           done,
    input  logic                                           w_we,
    input  logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0]     w_in_addr,
    input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0]   w_out_addr,
    input  logic [W_WIDTH-1:0]                             w_data,
    output logic [N_OUT*CNT_WIDTH-1:0]                     spike_cnt
);
    // state  | meaning
    // IDLE   | ready high, weights writable, waiting for start
    // SAMPLE | sample high, waiting for sample_ready to latch in_spikes
    // INTEG  | add weight row idx to every membrane when latched bit idx is set
    // FIRE   | threshold compare, reset or leak, publish out_spikes
    typedef enum logic [1:0] {IDLE, SAMPLE, INTEG, FIRE} state_t;

    localparam int IA_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic signed [V_WIDTH-1:0] THR   = V_WIDTH'(THRESHOLD);
    localparam logic signed [V_WIDTH:0]   V_MAX = {2'b00, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH:0]   V_MIN = {2'b11, {(V_WIDTH-1){1'b0}}};

    state_t                           state;
    logic [N_IN-1:0]                  spikes_q;
    logic [IA_W-1:0]                  idx;
    logic [CYCLES_CNT_BITWIDTH-1:0]   step;
    logic signed [W_WIDTH-1:0]        weight [N_IN][N_OUT];
    logic signed [V_WIDTH-1:0]        v      [N_OUT];

    logic signed [V_WIDTH:0]          v_sum  [N_OUT];
    logic signed [V_WIDTH-1:0]        v_sat  [N_OUT];
    logic signed [V_WIDTH-1:0]        v_leak [N_OUT];
    logic [N_OUT-1:0]                 fire;

    // One guard bit on the sum makes both saturation directions a plain signed compare.
    always_comb begin
        fire = '0;
        for (int i = 0; i < N_OUT; i++) begin
            v_sum[i] = {v[i][V_WIDTH-1], v[i]}
                     + {{(V_WIDTH+1-W_WIDTH){weight[idx][i][W_WIDTH-1]}}, weight[idx][i]};
            if (v_sum[i] > V_MAX)
                v_sat[i] = V_MAX[V_WIDTH-1:0];
            else if (v_sum[i] < V_MIN)
                v_sat[i] = V_MIN[V_WIDTH-1:0];
            else
                v_sat[i] = v_sum[i][V_WIDTH-1:0];
            v_leak[i] = v[i] - (v[i] >>> LEAK_SHIFT);
            fire[i]   = (v[i] >= THR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ready      <= 1'b1;
            sample     <= 1'b0;
            out_spikes <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            spikes_q   <= '0;
            idx        <= '0;
            step       <= '0;
            for (int j = 0; j < N_IN; j++)
                for (int i = 0; i < N_OUT; i++)
                    weight[j][i] <= '0;
            for (int i = 0; i < N_OUT; i++)
                v[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_we && int'(w_in_addr) < N_IN && int'(w_out_addr) < N_OUT)
                        weight[w_in_addr][w_out_addr] <= w_data;
                    if (start) begin
                        state  <= SAMPLE;
                        ready  <= 1'b0;
                        sample <= 1'b1;
                        step   <= '0;
                        for (int i = 0; i < N_OUT; i++)
                            v[i] <= '0;
                    end
                end
                SAMPLE: begin
                    if (sample_ready) begin
                        spikes_q <= in_spikes;
                        idx      <= '0;
                        sample   <= 1'b0;
                        state    <= INTEG;
                    end
                end
                INTEG: begin
                    if (spikes_q[idx])
                        for (int i = 0; i < N_OUT; i++)
                            v[i] <= v_sat[i];
                    if (idx == IA_W'(N_IN - 1))
                        state <= FIRE;
                    else
                        idx <= idx + 1'b1;
                end
                FIRE: begin
                    for (int i = 0; i < N_OUT; i++)
                        v[i] <= fire[i] ? '0 : v_leak[i];
                    out_spikes <= fire;
                    out_valid  <= 1'b1;
                    step       <= step + 1'b1;
                    if (step == CYCLES_CNT_BITWIDTH'(N_CYCLES - 1)) begin
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        sample <= 1'b1;
                        state  <= SAMPLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SNN_SPIKE_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt [N_OUT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_OUT; i++)
                cnt[i] <= '0;
        end else if (state == IDLE && start) begin
            for (int i = 0; i < N_OUT; i++)
                cnt[i] <= '0;
        end else if (state == FIRE) begin
            for (int i = 0; i < N_OUT; i++)
                if (fire[i] && cnt[i] != {CNT_WIDTH{1'b1}})
                    cnt[i] <= cnt[i] + 1'b1;
        end
    end

    always_comb begin
        spike_cnt = '0;
        for (int i = 0; i < N_OUT; i++)
            spike_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end
`else
    assign spike_cnt = '0;
`endif

endmodule

// File: tb/tb_snn_lif_layer.sv
// Directed bench for snn_lif_layer: a default instance and a V_WIDTH=8 instance share one stimulus stream.
// Spike-count expectations follow SNN_SPIKE_COUNT_EN the same way the design does.
module tb_snn_lif_layer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sample_ready = 1'b0;
    logic [3:0]  in_spikes = '0;
    logic        w_we = 1'b0;
    logic [1:0]  w_in_addr = '0;
    logic [0:0]  w_out_addr = '0;
    logic [7:0]  w_data = '0;

    logic        a_ready, a_sample, a_out_valid, a_done;
    logic [1:0]  a_out_spikes;
    logic [15:0] a_spike_cnt;
    logic        b_ready, b_sample, b_out_valid, b_done;
    logic [1:0]  b_out_spikes;
    logic [15:0] b_spike_cnt;

    int checks = 0;
    int errors = 0;

    snn_lif_layer dut_a (
        .clk(clk), .rst(rst), .start(start), .ready(a_ready), .sample(a_sample),
        .sample_ready(sample_ready), .in_spikes(in_spikes), .out_spikes(a_out_spikes),
        .out_valid(a_out_valid), .done(a_done), .w_we(w_we), .w_in_addr(w_in_addr),
        .w_out_addr(w_out_addr), .w_data(w_data), .spike_cnt(a_spike_cnt)
    );

    snn_lif_layer #(.V_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .ready(b_ready), .sample(b_sample),
        .sample_ready(sample_ready), .in_spikes(in_spikes), .out_spikes(b_out_spikes),
        .out_valid(b_out_valid), .done(b_done), .w_we(w_we), .w_in_addr(w_in_addr),
        .w_out_addr(w_out_addr), .w_data(w_data), .spike_cnt(b_spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all_w(input logic [7:0] d);
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                w_we = 1'b1; w_in_addr = 2'(j); w_out_addr = 1'(i); w_data = d;
            end
        end
        @(negedge clk);
        w_we = 1'b0;
    endtask

    function automatic logic [15:0] exp_cnt(input logic [9:0] mask);
`ifdef SNN_SPIKE_COUNT_EN
        return {2{8'($countones(mask))}};
`else
        return (mask == 10'h3FF) ? 16'h0 : 16'h0 | {15'h0, 1'b0};
`endif
    endfunction

    // Runs one inference; fa/fb give the steps (bit n = step n+1) where both neurons fire.
    // pre/post are the neuron-0 membranes in the first FIRE cycle and right after it.
    task automatic run(input string name, input logic [3:0] sp,
                       input logic [9:0] fa, input logic [9:0] fb,
                       input int pre_a, input int post_a, input int pre_b, input int post_b,
                       input int stall_after, input bit we_during, input bit hold);
        int nv = 0;
        int cyc = 0;
        int stall_left = 0;
        bit fin = 0;
        logic [63:0] prev_a = '0;
        logic [63:0] prev_b = '0;
        @(negedge clk);
        start = 1'b1; sample_ready = 1'b1; in_spikes = sp;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (we_during) begin
                w_we = 1'b1; w_in_addr = 2'd0; w_out_addr = 1'b0; w_data = 8'h80;
            end
            if (a_out_valid) begin
                if (stall_left > 0) chk({name, "_stall_valid"}, 64'(stall_left), 64'd0);
                chk({name, "_spk_a"}, 64'(a_out_spikes), fa[nv] ? 64'd3 : 64'd0);
                chk({name, "_spk_b"}, 64'(b_out_spikes), fb[nv] ? 64'd3 : 64'd0);
                chk({name, "_done"}, 64'(a_done), (nv == 9) ? 64'd1 : 64'd0);
                chk({name, "_ready"}, 64'(a_ready), (nv == 9) ? 64'd1 : 64'd0);
                if (nv == 0) begin
                    chk({name, "_pre_a"}, prev_a, 64'(pre_a));
                    chk({name, "_post_a"}, 64'(dut_a.v[0]), 64'(post_a));
                    chk({name, "_pre_b"}, prev_b, 64'(pre_b));
                    chk({name, "_post_b"}, 64'(dut_b.v[0]), 64'(post_b));
                end
                if (a_done) begin
                    fin = 1;
                    w_we = 1'b0;
                    chk({name, "_cnt_a"}, 64'(a_spike_cnt), 64'(exp_cnt(fa)));
                    chk({name, "_cnt_b"}, 64'(b_spike_cnt), 64'(exp_cnt(fb)));
                    chk({name, "_done_b"}, 64'(b_done), 64'd1);
                end
                nv++;
                if (nv == stall_after) begin
                    sample_ready = 1'b0;
                    stall_left = 6;
                end
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    chk({name, "_stall_sample_a"}, 64'(a_sample), 64'd1);
                    chk({name, "_stall_sample_b"}, 64'(b_sample), 64'd1);
                    sample_ready = 1'b1;
                end
            end
            prev_a = 64'(dut_a.v[0]);
            prev_b = 64'(dut_b.v[0]);
        end
        w_we = 1'b0;
        chk({name, "_valid_count"}, 64'(nv), 64'd10);
        if (!hold) begin
            repeat (3) @(negedge clk);
            chk({name, "_hold_spk"}, 64'(a_out_spikes), fa[9] ? 64'd3 : 64'd0);
            chk({name, "_idle_ready"}, 64'(a_ready), 64'd1);
        end
    endtask

    initial begin
        bit done_seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(a_ready), 64'd1);
        chk("rst_sample", 64'(a_sample), 64'd0);
        chk("rst_spk", 64'(a_out_spikes), 64'd0);
        chk("rst_valid", 64'(a_out_valid), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_cnt", 64'(a_spike_cnt), 64'd0);

        // every step: 4*32=128 fires; the 8-bit membrane clips at 127 first
        set_all_w(8'd32);
        run("all32", 4'hF, 10'h3FF, 10'h3FF, 128, 0, 127, 0, -1, 0, 0);

        // 16 -> 14, 27, 38, 48, then 64 fires at step 5 and again at step 10; stall before step 4
        set_all_w(8'd16);
        run("leak16", 4'h1, 10'h210, 10'h210, 16, 14, 16, 14, 3, 0, 0);

        // -512 leaks to -448; the 8-bit membrane pins at -128 and leaks to -112
        set_all_w(8'h80);
        run("neg_sat", 4'hF, 10'h000, 10'h000, -512, -448, -128, -112, -1, 0, 0);

        // writes of -128 to weight[0][0] during the run must not land
        set_all_w(8'd127);
        run("pos_sat", 4'hF, 10'h3FF, 10'h3FF, 508, 0, 127, 0, -1, 1, 0);

        // reset in the middle of INTEG
        set_all_w(8'd32);
        @(negedge clk);
        start = 1'b1; sample_ready = 1'b1; in_spikes = 4'hF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_async_spk", 64'(a_out_spikes), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(a_ready), 64'd1);
        chk("midrst_sample", 64'(a_sample), 64'd0);
        chk("midrst_spk_b", 64'(b_out_spikes), 64'd0);
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (a_done || a_out_valid) done_seen = 1;
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);
        run("zero_w", 4'hF, 10'h000, 10'h000, 0, 0, 0, 0, -1, 0, 0);

        // start held high: one ready cycle then a fresh run from zero membranes
        set_all_w(8'd16);
        run("hold1", 4'h1, 10'h210, 10'h210, 16, 14, 16, 14, -1, 0, 1);
        @(negedge clk);
        chk("hold_ready_low", 64'(a_ready), 64'd0);
        chk("hold_sample_high", 64'(a_sample), 64'd1);
        run("hold2", 4'h1, 10'h210, 10'h210, 16, 14, 16, 14, -1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
